// File: rtl/mem_d2_stream_reader_pkg.sv
// Shared types for the 2-D memory stream reader.
// Sequencer states and scan-order encodings.
package mem_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  localparam logic ROW_MAJOR = 1'b0;
  localparam logic COL_MAJOR = 1'b1;

endpackage

// File: rtl/mem_d2_stream_reader_addr_walker.sv
// Two nested wrapping address counters for a 2-D scan.
// The fast counter is addr1 in row-major order, addr0 in column-major.
module mem_d2_addr_walker #(
  parameter int D0_SIZE     = 16,
  parameter int D1_SIZE     = 16,
  parameter int D0_IDX_SIZE = 4,
  parameter int D1_IDX_SIZE = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   step,
  input  logic                   order,
  output logic [D0_IDX_SIZE-1:0] addr0,
  output logic [D1_IDX_SIZE-1:0] addr1,
  output logic                   last
);
  import mem_stream_pkg::*;

  localparam logic [D0_IDX_SIZE-1:0] MAX0 =
    D0_IDX_SIZE'(D0_SIZE - 1);
  localparam logic [D1_IDX_SIZE-1:0] MAX1 =
    D1_IDX_SIZE'(D1_SIZE - 1);
  localparam logic [D0_IDX_SIZE-1:0] ONE0 =
    D0_IDX_SIZE'(1);
  localparam logic [D1_IDX_SIZE-1:0] ONE1 =
    D1_IDX_SIZE'(1);

  logic [D0_IDX_SIZE-1:0] r_addr0;
  logic [D1_IDX_SIZE-1:0] r_addr1;
  logic                   w_end0;
  logic                   w_end1;

  assign w_end0 = (r_addr0 == MAX0);
  assign w_end1 = (r_addr1 == MAX1);

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      r_addr0 <= '0;
      r_addr1 <= '0;
    end else if (step) begin
      if (order == ROW_MAJOR) begin
        if (w_end1) begin
          r_addr1 <= '0;
          r_addr0 <= w_end0 ? '0 : r_addr0 + ONE0;
        end else begin
          r_addr1 <= r_addr1 + ONE1;
        end
      end else begin
        if (w_end0) begin
          r_addr0 <= '0;
          r_addr1 <= w_end1 ? '0 : r_addr1 + ONE1;
        end else begin
          r_addr0 <= r_addr0 + ONE0;
        end
      end
    end
  end

  assign addr0 = r_addr0;
  assign addr1 = r_addr1;
  assign last  = w_end0 && w_end1;

endmodule

// File: rtl/mem_d2_stream_reader.sv
// Drains a combinational-read 2-D memory as a valid/ready stream.
// One-entry output register; done pulses after the final accept.
module mem_d2_stream_reader #(
  parameter int WIDTH       = 32,
  parameter int D0_SIZE     = 16,
  parameter int D1_SIZE     = 16,
  parameter int D0_IDX_SIZE = 4,
  parameter int D1_IDX_SIZE = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   go,
  input  logic                   col_major,
  output logic [D0_IDX_SIZE-1:0] addr0,
  output logic [D1_IDX_SIZE-1:0] addr1,
  input  logic [WIDTH-1:0]       read_data,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   done
);
  import mem_stream_pkg::*;

  state_t           r_state;
  state_t           w_next;
  logic             r_order;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_done;

  logic w_load;
  logic w_accept;
  logic w_clear;
  logic w_step;
  logic w_last;

  assign w_accept = r_out_valid && out_ready;

  mem_d2_addr_walker #(
    .D0_SIZE    (D0_SIZE),
    .D1_SIZE    (D1_SIZE),
    .D0_IDX_SIZE(D0_IDX_SIZE),
    .D1_IDX_SIZE(D1_IDX_SIZE)
  ) u_walker (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (w_clear),
    .step   (w_step),
    .order  (r_order),
    .addr0  (addr0),
    .addr1  (addr1),
    .last   (w_last)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_clear = 1'b0;
    w_step  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_clear = 1'b1;
        if (go) w_next = STREAM;
      end
      STREAM: begin
        w_load = !r_out_valid || out_ready;
        if (w_load) begin
          if (w_last) w_next = DRAIN;
          else        w_step = 1'b1;
        end
      end
      DRAIN: begin
        // counters return to 0,0 together with the IDLE transition
        if (w_accept) begin
          w_next  = IDLE;
          w_clear = 1'b1;
        end
      end
      default: begin
        w_next  = IDLE;
        w_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_order     <= ROW_MAJOR;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (r_state == DRAIN) && w_accept;
      if (r_state == IDLE && go) r_order <= col_major;
      if (w_load) begin
        r_out_data  <= read_data;
        r_out_valid <= 1'b1;
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign done      = r_done;

endmodule
